hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Each cycle it computes the stall and flush controls driven into the F/D and D/E pipeline registers and the PC enable. It covers three cases: register RAW hazards, which use Tuse/Tnew comparison; multiply/divide-unit occupancy, which uses an internal busy countdown; and exception/interrupt requests from CP0. It sits beside the decode stage and also keeps a saturating stall-cycle performance counter.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu issue
- DIV_CYCLES, 10, busy cycles after a div/divu issue
- CNT_W, 4, width of the busy countdown; must hold DIV_CYCLES

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- D_rs, D_rt  in  5 each  source register numbers of the instruction in D
- D_tuse_rs, D_tuse_rt  in  2 each  cycles until the operand is needed (0..2); 3 = operand unused
- D_is_md  in  1  D instruction uses HI/LO or the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- E_a3, M_a3  in  5 each  destination register in E / M; 0 = no write
- E_tnew, M_tnew  in  2 each  cycles until the E / M result is forwardable
- E_md_start  in  1  E instruction starts an MDU operation this cycle
- E_md_div  in  1  1 = divide, 0 = multiply; valid with E_md_start
- req  in  1  CP0 exception/interrupt taken this cycle
- pc_en  out  1  PC update enable
- fd_stall  out  1  hold the F/D register
- de_flush  out  1  insert a bubble into the D/E register
- md_busy  out  1  MDU countdown nonzero
- stall_cycles  out  32  saturating count of stalled cycles

## Operation
- RAW hazard on rs: D_rs≠0 and D_tuse_rs≠3 and either of:
  - D_rs==E_a3 and D_tuse_rs<E_tnew
  - D_rs==M_a3 and D_tuse_rs<M_tnew
- RAW hazard on rt: same rule using the rt signals.
- MDU stall: D_is_md and (md_busy or E_md_start).
- stall = rs hazard | rt hazard | MDU stall.
- Outputs when req=0: fd_stall=stall, de_flush=stall, pc_en=~stall.
- Outputs when req=1: fd_stall=0, de_flush=0, pc_en=1. The pipeline registers give req priority and load the handler PC.
- Busy countdown, in priority order:
  1. reset → cnt=0.
  2. E_md_start & ~req → cnt = E_md_div ? DIV_CYCLES : MULT_CYCLES.
  3. cnt≠0 → cnt−1.
  4. Otherwise hold.
- req does not abort an operation already counting; only a same-cycle start is suppressed.
- E_md_start while cnt≠0 cannot occur, because the MDU stall blocks it. If it does occur, the reload rule (step 2) applies.
- md_busy = (cnt≠0), a registered value.
- stall_cycles increments on every cycle with stall & ~req and saturates at 0xFFFFFFFF. reset clears it.

## Timing
- Reset values: cnt=0, md_busy=0, stall_cycles=0.
- pc_en, fd_stall and de_flush are combinational from the current inputs and cnt, with zero latency. With all inputs at zero: pc_en=1, fd_stall=0, de_flush=0.
- A mult issued (E_md_start) at edge t gives md_busy=1 for the 5 cycles after t. An mflo held in D stalls during the issue cycle and those 5 cycles, and advances on the 6th.
- A div gives 10 busy cycles, with the same stall rule.
- Tnew-based stalls release as soon as the producer advances and its Tnew drops to ≤ Tuse. No state is kept.
- Reset asserted mid-countdown clears cnt at that edge; md_busy is 0 on the next cycle.

## Structure
- Shared package:
  - TUSE_NONE=2'd3
  - MULT_CYCLES and DIV_CYCLES defaults
  - register-number width 5
- One natural sub-module, md_busy_counter: the reload/decrement countdown. It takes start, div and req, and outputs busy.
- The hazard compare is plain logic in hazard_ctrl, with the rs and rt paths symmetric.

## Test plan
- lw in E (E_a3=8, E_tnew=2), addu in D (D_rs=8, D_tuse_rs=1) → fd_stall=de_flush=1, pc_en=0. After the producer moves to M with M_tnew=1 → no stall.
- D_rs=0 with E_a3=0, E_tnew=2, D_tuse_rs=0 → no stall, because register 0 is exempt.
- mult start at cycle 0, then mflo in D → stall cycles 0–5, release at cycle 6; stall_cycles=6.
- div start → md_busy high exactly 10 cycles. Reset at busy cycle 4 → md_busy=0 next cycle.
- req=1 with an active RAW hazard and E_md_start=1 → pc_en=1, fd_stall=de_flush=0, cnt stays 0, stall_cycles unchanged.
- Force stall_cycles to 0xFFFFFFFE, stall 3 cycles → reads 0xFFFFFFFF with no wrap.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared types and constants for the decode-stage hazard controller.
//   REG_W           : architectural register-number width
//   TUSE_NONE       : Tuse encoding for "operand not read by this instruction"
//   *_DEF           : default MDU latencies and countdown width
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_num_t;
  typedef logic [1:0]       timing_t;   // Tuse / Tnew in cycles

  localparam timing_t TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // Number of register source operands checked in decode (rs, rt).
  localparam int NUM_SRC = 2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundle of decode/execute/memory hazard inputs and pipeline control outputs.
//   Inputs to the controller : D_rs/D_rt + Tuse, D_is_md, E/M destination + Tnew,
//                              E_md_start/E_md_div, CP0 req
//   Outputs from controller  : pc_en, fd_stall, de_flush, md_busy, stall_cycles
//   modport slave  : the hazard controller
//   modport master : the pipeline side that drives the requests
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_num_t    D_rs;
  reg_num_t    D_rt;
  timing_t     D_tuse_rs;
  timing_t     D_tuse_rt;
  logic        D_is_md;
  reg_num_t    E_a3;
  reg_num_t    M_a3;
  timing_t     E_tnew;
  timing_t     M_tnew;
  logic        E_md_start;
  logic        E_md_div;
  logic        req;

  logic        pc_en;
  logic        fd_stall;
  logic        de_flush;
  logic        md_busy;
  logic [31:0] stall_cycles;

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_a3, M_a3, E_tnew, M_tnew, E_md_start, E_md_div, req,
    output pc_en, fd_stall, de_flush, md_busy, stall_cycles
  );

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_a3, M_a3, E_tnew, M_tnew, E_md_start, E_md_div, req,
    input  pc_en, fd_stall, de_flush, md_busy, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// md_busy_counter
// Models multiply/divide unit occupancy as a down-counter loaded on issue.
//   clk, reset : clock, synchronous active-high reset
//   start      : MDU operation issued from E this cycle
//   div        : 1 = divide latency, 0 = multiply latency (valid with start)
//   req        : CP0 exception/interrupt this cycle; suppresses a same-cycle
//                start but never aborts a count already running
//   busy       : countdown nonzero (straight from the register)
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic req,
  output logic busy
);

  generate
    if (DIV_CYCLES >= (1 << CNT_W) || MULT_CYCLES >= (1 << CNT_W)) begin : g_bad_width
      $error("md_busy_counter: CNT_W too narrow for the configured latencies");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A start reloads even if a count is running; the decode-side MDU stall
  // normally makes that impossible, so reload is the simple defined choice.
  always_comb begin
    cnt_d = cnt_q;
    if (start && !req) begin
      cnt_d = div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Decode-stage hazard controller for the five-stage pipeline. Produces the
// F/D hold, D/E bubble and PC enable from RAW (Tuse/Tnew) hazards and MDU
// occupancy; a CP0 request overrides every stall. Also counts stalled cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_ctrl_if.slave (see interface for the signal list)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  // ------------------------------------------------------------------
  // RAW hazards: rs and rt go through identical compare logic.
  // A stall is needed when the consumer needs the value sooner than the
  // producer can forward it (Tuse < Tnew). $zero never creates a hazard.
  // ------------------------------------------------------------------
  reg_num_t        src_reg  [NUM_SRC];
  timing_t         src_tuse [NUM_SRC];
  logic [NUM_SRC-1:0] src_hazard;

  assign src_reg[0]  = bus.D_rs;
  assign src_reg[1]  = bus.D_rt;
  assign src_tuse[0] = bus.D_tuse_rs;
  assign src_tuse[1] = bus.D_tuse_rt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic hit_e;
      logic hit_m;
      assign hit_e = (src_reg[gi] == bus.E_a3) && (src_tuse[gi] < bus.E_tnew);
      assign hit_m = (src_reg[gi] == bus.M_a3) && (src_tuse[gi] < bus.M_tnew);
      assign src_hazard[gi] = (src_reg[gi] != '0) && (src_tuse[gi] != TUSE_NONE)
                              && (hit_e || hit_m);
    end
  endgenerate

  // ------------------------------------------------------------------
  // MDU occupancy
  // ------------------------------------------------------------------
  logic md_busy;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk   (clk),
    .reset (reset),
    .start (bus.E_md_start),
    .div   (bus.E_md_div),
    .req   (bus.req),
    .busy  (md_busy)
  );

  // An HI/LO user in D also waits during the issue cycle itself, before the
  // countdown register has been loaded.
  logic md_stall;
  assign md_stall = bus.D_is_md && (md_busy || bus.E_md_start);

  logic stall;
  assign stall = (|src_hazard) || md_stall;

  // ------------------------------------------------------------------
  // Pipeline controls: a CP0 request wins so the handler PC is loaded.
  // ------------------------------------------------------------------
  always_comb begin
    bus.pc_en    = 1'b1;
    bus.fd_stall = 1'b0;
    bus.de_flush = 1'b0;
    if (!bus.req) begin
      bus.pc_en    = !stall;
      bus.fd_stall = stall;
      bus.de_flush = stall;
    end
  end

  assign bus.md_busy = md_busy;

  // ------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ------------------------------------------------------------------
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !bus.req && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;

endmodule
